// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the shift arbiter: op and state encodings, plus a
// 32-bit bit-reversal helper used to turn the left shifter into a right shifter.
package shift_arbiter_pkg;

  typedef enum logic [1:0] {
    OpSll = 2'b00,
    OpSrl = 2'b01,
    OpSra = 2'b10,
    OpIll = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StFill = 2'b10,
    StResp = 2'b11
  } state_e;

  localparam int unsigned ShiftWidth = 32;

  function automatic logic [31:0] bitrev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = x[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_arbiter_left_shift.sv
// Combinational 32-bit logical left shifter, the shared datapath.
//   in1 : operand
//   in2 : shift amount (0..31)
//   out : in1 << in2, zero filled
module left_shift (
  input  logic [31:0] in1,
  input  logic [4:0]  in2,
  output logic [31:0] out
);

  assign out = in1 << in2;

endmodule

// File: rtl/shift_arbiter.sv
// Arbitrates two requesters onto one left shifter and sequences SLL, SRL and
// SRA through it. Right shifts reverse the operand and result bits; SRA adds a
// second pass that shifts an all-ones word to build the sign-fill mask.
//   clk, rst    : clock, asynchronous active-high reset
//   req_valid   : per-requester request valid
//   req_ready   : one-hot grant, only ever high in idle
//   req_op      : 2-bit op per requester (SLL/SRL/SRA/illegal)
//   req_a       : 32-bit operand per requester
//   req_b       : 32-bit shift amount per requester, low 5 bits used
//   resp_valid  : result valid for the owning requester
//   resp_ready  : per-requester result accept
//   resp_data   : registered result, shared
//   resp_err    : set when the op was illegal
//   busy        : high whenever not idle
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter bit          FAIR  = 1'b1,
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [3:0]           req_op,
  input  logic [2*WIDTH-1:0]   req_a,
  input  logic [2*WIDTH-1:0]   req_b,
  output logic [1:0]           resp_valid,
  input  logic [1:0]           resp_ready,
  output logic [WIDTH-1:0]     resp_data,
  output logic                 resp_err,
  output logic                 busy
);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             ptr_q, ptr_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [4:0]       sh_q, sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;

  logic             gnt;
  logic [31:0]      shift_in1, shift_out;
  logic [4:0]       shift_in2;

  logic [1:0]       lane_op [2];
  logic [WIDTH-1:0] lane_a  [2];
  logic [4:0]       lane_sh [2];

  assign lane_op[0] = req_op[1:0];
  assign lane_op[1] = req_op[3:2];
  assign lane_a[0]  = req_a[WIDTH-1:0];
  assign lane_a[1]  = req_a[2*WIDTH-1:WIDTH];
  assign lane_sh[0] = req_b[4:0];
  assign lane_sh[1] = req_b[WIDTH+4:WIDTH];

  // Upper bits of the shift amount lanes are intentionally ignored.
  logic unused_b;
  assign unused_b = ^{req_b[2*WIDTH-1:WIDTH+5], req_b[WIDTH-1:5]};

  left_shift u_left_shift (
    .in1 (shift_in1),
    .in2 (shift_in2),
    .out (shift_out)
  );

  // Round-robin prefers the pointer requester; fixed priority prefers 0.
  always_comb begin
    if (FAIR) begin
      gnt = req_valid[ptr_q] ? ptr_q : ~ptr_q;
    end else begin
      gnt = req_valid[0] ? 1'b0 : 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    op_d       = op_q;
    a_d        = a_q;
    sh_d       = sh_q;
    result_d   = result_q;
    err_d      = err_q;
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    shift_in1  = '0;
    shift_in2  = '0;

    unique case (state_q)
      StIdle: begin
        if (|req_valid) begin
          req_ready[gnt] = 1'b1;
          owner_d        = gnt;
          op_d           = op_e'(lane_op[gnt]);
          a_d            = lane_a[gnt];
          sh_d           = lane_sh[gnt];
          state_d        = StExec;
        end
      end
      StExec: begin
        shift_in2 = sh_q;
        err_d     = 1'b0;
        state_d   = StResp;
        unique case (op_q)
          OpSll: begin
            shift_in1 = a_q;
            result_d  = shift_out;
          end
          OpSrl, OpSra: begin
            shift_in1 = bitrev32(a_q);
            result_d  = bitrev32(shift_out);
            if (op_q == OpSra) state_d = StFill;
          end
          default: begin
            result_d = '0;
            err_d    = 1'b1;
          end
        endcase
      end
      StFill: begin
        // Shifting all-ones left then reversing marks the vacated top bits.
        shift_in1 = '1;
        shift_in2 = sh_q;
        if (a_q[WIDTH-1]) result_d = result_q | ~bitrev32(shift_out);
        state_d = StResp;
      end
      StResp: begin
        resp_valid[owner_q] = 1'b1;
        if (resp_ready[owner_q]) begin
          state_d = StIdle;
          if (FAIR) ptr_d = ~owner_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      ptr_q    <= 1'b0;
      op_q     <= OpSll;
      a_q      <= '0;
      sh_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      op_q     <= op_d;
      a_q      <= a_d;
      sh_q     <= sh_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign resp_data = result_q;
  assign resp_err  = err_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: one round-robin instance plus one
// fixed-priority instance sharing operand lanes.
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [3:0]  req_op;
  logic [63:0] req_a, req_b;
  logic [31:0] resp_data;
  logic        resp_err, busy;

  logic [1:0]  fp_req_valid, fp_req_ready, fp_resp_valid, fp_resp_ready;
  logic [31:0] fp_resp_data;
  logic        fp_resp_err, fp_busy;

  int checks;
  int passed;

  always #5 clk = ~clk;

  shift_arbiter #(.FAIR(1'b1), .WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  shift_arbiter #(.FAIR(1'b0), .WIDTH(32)) dut_fp (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (fp_req_valid),
    .req_ready  (fp_req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (fp_resp_valid),
    .resp_ready (fp_resp_ready),
    .resp_data  (fp_resp_data),
    .resp_err   (fp_resp_err),
    .busy       (fp_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int idx, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
    req_op[2*idx +: 2]  = op;
    req_a[32*idx +: 32] = a;
    req_b[32*idx +: 32] = b;
  endtask

  // Raise a request and hold it until granted; returns one cycle after the
  // accepting edge with the request dropped.
  task automatic accept(input int idx, input string name);
    bit ok = 1'b0;
    req_valid[idx] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req_ready[idx]) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
    end
    checks++;
    if (!ok) $display("FAIL %s: req_ready got 0 want 1 within 20 cycles", name);
    else passed++;
    @(posedge clk);
    #1;
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_resp(input int idx, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (resp_valid[idx]) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) $display("FAIL %s: resp_valid[%0d] got 0 want 1 within 10 cycles", name, idx);
    else passed++;
  endtask

  task automatic ack(input int idx);
    resp_ready[idx] = 1'b1;
    tick();
    resp_ready[idx] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    resp_ready = '0;
    fp_req_valid = '0;
    fp_resp_ready = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_err, busy} !== 6'b0)
      $display("FAIL reset_ctrl: got %b want 000000", {req_ready, resp_valid, resp_err, busy});
    else passed++;
    checks++;
    if (resp_data !== 32'h0) $display("FAIL reset_data: got %h want 00000000", resp_data);
    else passed++;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_sll();
    set_lane(0, 2'b00, 32'h0000_0001, 32'd4);
    accept(0, "sll_accept");
    checks++;
    if (resp_valid !== 2'b00 || busy !== 1'b1)
      $display("FAIL sll_exec: resp_valid %b busy %b want 00 1", resp_valid, busy);
    else passed++;
    tick();
    checks++;
    if (resp_valid !== 2'b01 || resp_data !== 32'h10 || resp_err !== 1'b0)
      $display("FAIL sll_resp: got %b %h %b want 01 00000010 0", resp_valid, resp_data, resp_err);
    else passed++;
    ack(0);
    checks++;
    if (resp_valid !== 2'b00 || busy !== 1'b0)
      $display("FAIL sll_done: resp_valid %b busy %b want 00 0", resp_valid, busy);
    else passed++;
  endtask

  task automatic test_sra_srl();
    set_lane(1, 2'b10, 32'h8000_0000, 32'd4);
    accept(1, "sra_accept");
    checks++;
    if (resp_valid !== 2'b00) $display("FAIL sra_exec: resp_valid %b want 00", resp_valid);
    else passed++;
    tick();
    checks++;
    if (resp_valid !== 2'b00) $display("FAIL sra_fill: resp_valid %b want 00", resp_valid);
    else passed++;
    tick();
    checks++;
    if (resp_valid !== 2'b10 || resp_data !== 32'hF800_0000)
      $display("FAIL sra_resp: got %b %h want 10 f8000000", resp_valid, resp_data);
    else passed++;
    ack(1);
    set_lane(1, 2'b01, 32'h8000_0000, 32'd4);
    accept(1, "srl_accept");
    tick();
    checks++;
    if (resp_valid !== 2'b10 || resp_data !== 32'h0800_0000)
      $display("FAIL srl_resp: got %b %h want 10 08000000", resp_valid, resp_data);
    else passed++;
    ack(1);
  endtask

  task automatic test_arbitration();
    do_reset();
    set_lane(0, 2'b00, 32'h1, 32'd1);
    set_lane(1, 2'b00, 32'h1, 32'd2);
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) $display("FAIL rr_first: req_ready %b want 01", req_ready);
    else passed++;
    tick();
    req_valid[0] = 1'b0;
    wait_resp(0, "rr_resp0");
    checks++;
    if (resp_data !== 32'h2) $display("FAIL rr_data0: got %h want 00000002", resp_data);
    else passed++;
    ack(0);
    checks++;
    if (req_ready !== 2'b10) $display("FAIL rr_second: req_ready %b want 10", req_ready);
    else passed++;
    tick();
    req_valid[1] = 1'b0;
    wait_resp(1, "rr_resp1");
    checks++;
    if (resp_data !== 32'h4) $display("FAIL rr_data1: got %h want 00000004", resp_data);
    else passed++;
    ack(1);

    // Fixed priority: requester 0 keeps re-requesting and keeps winning.
    fp_req_valid = 2'b11;
    #1;
    checks++;
    if (fp_req_ready !== 2'b01) $display("FAIL fp_first: req_ready %b want 01", fp_req_ready);
    else passed++;
    for (int i = 0; i < 10 && fp_resp_valid !== 2'b01; i++) tick();
    checks++;
    if (fp_resp_valid !== 2'b01 || fp_resp_data !== 32'h2)
      $display("FAIL fp_resp: got %b %h want 01 00000002", fp_resp_valid, fp_resp_data);
    else passed++;
    fp_resp_ready = 2'b01;
    tick();
    fp_resp_ready = 2'b00;
    checks++;
    if (fp_req_ready !== 2'b01) $display("FAIL fp_second: req_ready %b want 01", fp_req_ready);
    else passed++;
    fp_req_valid = 2'b00;
  endtask

  task automatic test_backpressure();
    do_reset();
    set_lane(0, 2'b00, 32'h0000_1234, 32'd8);
    set_lane(1, 2'b01, 32'h0000_00F0, 32'd4);
    accept(0, "bp_accept");
    req_valid[1] = 1'b1;
    wait_resp(0, "bp_resp");
    resp_ready[1] = 1'b1;  // non-owner ready must be ignored
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (resp_valid !== 2'b01 || resp_data !== 32'h0012_3400 || req_ready !== 2'b00 ||
          busy !== 1'b1)
        $display("FAIL bp_hold%0d: got %b %h %b %b want 01 00123400 00 1", i, resp_valid,
                 resp_data, req_ready, busy);
      else passed++;
      tick();
    end
    resp_ready[1] = 1'b0;
    ack(0);
    checks++;
    if (req_ready !== 2'b10) $display("FAIL bp_next_grant: req_ready %b want 10", req_ready);
    else passed++;
    tick();
    req_valid[1] = 1'b0;
    wait_resp(1, "bp_resp1");
    checks++;
    if (resp_data !== 32'h0000_000F) $display("FAIL bp_data1: got %h want 0000000f", resp_data);
    else passed++;
    ack(1);
  endtask

  task automatic test_edge_ops();
    set_lane(0, 2'b11, 32'h0000_FFFF, 32'd3);
    accept(0, "ill_accept");
    wait_resp(0, "ill_resp");
    checks++;
    if (resp_data !== 32'h0 || resp_err !== 1'b1)
      $display("FAIL illegal: got %h %b want 00000000 1", resp_data, resp_err);
    else passed++;
    ack(0);
    set_lane(0, 2'b10, 32'hDEAD_BEEF, 32'd0);
    accept(0, "sra0_accept");
    wait_resp(0, "sra0_resp");
    checks++;
    if (resp_data !== 32'hDEAD_BEEF || resp_err !== 1'b0)
      $display("FAIL sra_zero: got %h %b want deadbeef 0", resp_data, resp_err);
    else passed++;
    ack(0);
    set_lane(0, 2'b10, 32'h8000_0000, 32'd31);
    accept(0, "sra31_accept");
    wait_resp(0, "sra31_resp");
    checks++;
    if (resp_data !== 32'hFFFF_FFFF) $display("FAIL sra_31: got %h want ffffffff", resp_data);
    else passed++;
    ack(0);
    set_lane(0, 2'b10, 32'h7000_0000, 32'd4);
    accept(0, "sra_pos_accept");
    wait_resp(0, "sra_pos_resp");
    checks++;
    if (resp_data !== 32'h0700_0000) $display("FAIL sra_pos: got %h want 07000000", resp_data);
    else passed++;
    ack(0);
  endtask

  task automatic test_reset_in_fill();
    set_lane(1, 2'b10, 32'h8000_0000, 32'd4);
    accept(1, "rf_accept");
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_err, busy} !== 6'b0 || resp_data !== 32'h0)
      $display("FAIL reset_fill: got %b %h want 000000 00000000",
               {req_ready, resp_valid, resp_err, busy}, resp_data);
    else passed++;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (resp_valid !== 2'b00) $display("FAIL no_stale%0d: resp_valid %b want 00", i, resp_valid);
      else passed++;
    end
    set_lane(0, 2'b00, 32'h3, 32'd2);
    accept(0, "post_rst_accept");
    wait_resp(0, "post_rst_resp");
    checks++;
    if (resp_data !== 32'hC || resp_valid !== 2'b01)
      $display("FAIL post_reset: got %b %h want 01 0000000c", resp_valid, resp_data);
    else passed++;
    ack(0);
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst = 1'b1;
    req_valid = '0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    resp_ready = '0;
    fp_req_valid = '0;
    fp_resp_ready = '0;
    test_reset();
    test_sll();
    test_sra_srl();
    test_arbitration();
    test_backpressure();
    test_edge_ops();
    test_reset_in_fill();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
